// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Shares one AXI read address/data channel pair between the instruction-side
// (I) and data-side (D) read requesters. Only one AXI read is in flight at a
// time. The burst is tagged with arid (0 = I, 1 = D) and returned beats are
// steered back to the owner.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate. The
//                                    side not served last wins.
//                       undefined -> fixed priority. D wins simultaneous
//                                    requests.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_req/i_addr/i_len/i_size    I-side burst request (held until i_gnt)
//   i_gnt                        1-cycle pulse on the I AR handshake
//   i_rdata/i_rvalid/i_rlast     beats returned to the I side
//   d_*                          same set for the D side
//   ar*                          AXI read address channel (master side)
//   rid/rdata/rresp/rlast/rvalid AXI read data channel inputs
//   rready                       AXI read data channel ready
module axi_rd_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic [2:0]        i_size,
    output logic              i_gnt,
    output logic [31:0]       i_rdata,
    output logic              i_rvalid,
    output logic              i_rlast,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_len,
    input  logic [2:0]        d_size,
    output logic              d_gnt,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Owner encoding matches arid bit 0: 0 = I side, 1 = D side.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [7:0]        len_q,   len_d;
    logic [2:0]        size_q,  size_d;
    logic              pick_d_side;

`ifdef ARB_ROUND_ROBIN_EN
    // Side that completed the most recent AR handshake.
    logic              last_q,  last_d;
`endif

    // rid and rresp are deliberately not checked: only one read is ever
    // outstanding, so every returned beat belongs to the current owner.
    logic unused_axi_fields;
    assign unused_axi_fields = ^{rid, rresp};

    // ------------------------------------------------------------------
    // State and burst registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= OWN_I;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Owner selection in IDLE
    // ------------------------------------------------------------------
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        // A lone D request always wins; a contended one wins only when
        // the I side was served last.
        pick_d_side = d_req && (!i_req || (last_q == OWN_I));
`else
        pick_d_side = d_req;
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = pick_d_side ? OWN_D : OWN_I;
                    addr_d  = pick_d_side ? d_addr : i_addr;
                    len_d   = pick_d_side ? d_len  : i_len;
                    size_d  = pick_d_side ? d_size : i_size;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_d = S_DATA;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = owner_q;
`endif
                end
            end
            S_DATA: begin
                // Requests are ignored here; a held req re-arbitrates
                // only after the burst returns to IDLE.
                if (rvalid && rlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        logic in_data;
        in_data  = (state_q == S_DATA);

        arvalid  = (state_q == S_ADDR);
        rready   = in_data;

        i_gnt    = arvalid && arready && (owner_q == OWN_I);
        d_gnt    = arvalid && arready && (owner_q == OWN_D);

        // Beats pass straight through to the owner; the other side sees 0.
        i_rvalid = (in_data && owner_q == OWN_I) ? rvalid : 1'b0;
        i_rlast  = (in_data && owner_q == OWN_I) ? rlast  : 1'b0;
        i_rdata  = (in_data && owner_q == OWN_I) ? rdata  : 32'd0;
        d_rvalid = (in_data && owner_q == OWN_D) ? rvalid : 1'b0;
        d_rlast  = (in_data && owner_q == OWN_D) ? rlast  : 1'b0;
        d_rdata  = (in_data && owner_q == OWN_D) ? rdata  : 32'd0;

        arid     = {3'b000, owner_q};
        araddr   = addr_q;
        arlen    = len_q;
        arsize   = size_q;
        arburst  = 2'b01;
        arlock   = 2'b00;
        arcache  = 4'b0000;
        arprot   = 3'b000;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req, d_req;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [7:0]        i_len, d_len;
    logic [2:0]        i_size, d_size;
    logic              i_gnt, d_gnt;
    logic [31:0]       i_rdata, d_rdata;
    logic              i_rvalid, d_rvalid, i_rlast, d_rlast;
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst, arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid, arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_size(i_size),
        .i_gnt(i_gnt), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: one transaction at a time, described as
    // "busy with a burst" and "address phase still open".
    bit          m_busy, m_aphase, m_own, m_last;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    int          s_left;       // beats the slave still owes
    bit          want_rv;      // slave willing to return a beat this cycle
    bit          e_ig, e_dg;   // grants the model predicted last cycle

    // Observed DUT outputs of the most recent cycle
    logic        obs_arvalid, obs_rready, obs_i_gnt, obs_d_gnt;
    logic        obs_i_rvalid, obs_i_rlast, obs_d_rvalid, obs_d_rlast;
    logic [31:0] obs_araddr;
    logic [7:0]  obs_arlen;
    logic [3:0]  obs_arid;
    logic [1:0]  obs_arburst;

    int beats, dbeats, last_at, arv_cnt, got;
    int pat[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Owner chosen when the arbiter picks up requests from idle.
    function automatic bit choose(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !m_last;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    // One clock cycle: drive slave, compare every output, advance model.
    task automatic step();
        bit e_arv, e_rr, fi, fd;
        rvalid = want_rv && m_busy && !m_aphase && (s_left > 0);
        rlast  = m_busy && !m_aphase && (s_left == 1);
        rdata  = $urandom;
        rid    = {3'b000, m_own};
        rresp  = 2'($urandom_range(0, 3));
        #1;
        e_arv = m_busy && m_aphase;
        e_rr  = m_busy && !m_aphase;
        fi    = e_rr && !m_own;
        fd    = e_rr && m_own;
        chk("arvalid", arvalid, e_arv);
        chk("rready", rready, e_rr);
        chk("i_gnt", i_gnt, e_arv && arready && !m_own);
        chk("d_gnt", d_gnt, e_arv && arready && m_own);
        chk("i_rvalid", i_rvalid, fi && rvalid);
        chk("i_rlast", i_rlast, fi && rlast);
        chk("i_rdata", i_rdata, fi ? rdata : 32'd0);
        chk("d_rvalid", d_rvalid, fd && rvalid);
        chk("d_rlast", d_rlast, fd && rlast);
        chk("d_rdata", d_rdata, fd ? rdata : 32'd0);
        chk("ar_const", {arburst, arlock, arcache, arprot}, {2'b01, 2'b00, 4'b0000, 3'b000});
        if (e_arv) begin
            chk("arid", arid, {3'b000, m_own});
            chk("araddr", araddr, m_addr);
            chk("arlen", arlen, m_len);
            chk("arsize", arsize, m_size);
        end
        obs_arvalid  = arvalid;  obs_rready   = rready;
        obs_i_gnt    = i_gnt;    obs_d_gnt    = d_gnt;
        obs_i_rvalid = i_rvalid; obs_i_rlast  = i_rlast;
        obs_d_rvalid = d_rvalid; obs_d_rlast  = d_rlast;
        obs_araddr   = araddr;   obs_arlen    = arlen;
        obs_arid     = arid;     obs_arburst  = arburst;
        e_ig = e_arv && arready && !m_own;
        e_dg = e_arv && arready && m_own;
        if (rst) begin
            m_busy = 0; m_aphase = 0; m_own = 0; m_last = 0; s_left = 0;
            m_addr = '0; m_len = '0; m_size = '0;
        end else if (!m_busy) begin
            if (i_req || d_req) begin
                m_own    = choose(i_req, d_req);
                m_addr   = m_own ? d_addr : i_addr;
                m_len    = m_own ? d_len  : i_len;
                m_size   = m_own ? d_size : i_size;
                m_busy   = 1;
                m_aphase = 1;
            end
        end else if (m_aphase) begin
            if (arready) begin
                m_aphase = 0;
                m_last   = m_own;
                s_left   = int'(m_len) + 1;
            end
        end else if (rvalid) begin
            s_left--;
            if (rlast) m_busy = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        want_rv = 1;
        arready = 1;
        while (m_busy && n < bound) begin
            step();
            n++;
        end
        chk("drain_done", m_busy, 0);
    endtask

    initial begin
        rst = 1; i_req = 0; d_req = 0; arready = 0; want_rv = 0;
        i_addr = '0; d_addr = '0; i_len = '0; d_len = '0; i_size = '0; d_size = '0;
        rvalid = 0; rlast = 0; rdata = '0; rid = '0; rresp = '0;
        m_busy = 0; m_aphase = 0; m_own = 0; m_last = 0; s_left = 0;
        m_addr = '0; m_len = '0; m_size = '0; e_ig = 0; e_dg = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // Reset state
        step();
        chk("reset_arvalid", obs_arvalid, 0);
        chk("reset_rready", obs_rready, 0);
        chk("reset_araddr", obs_araddr, 0);
        chk("reset_arlen", obs_arlen, 0);
        chk("reset_arid", obs_arid, 0);

        // I burst of 8 beats, arready high
        i_req = 1; i_addr = 32'h1FC0_0000; i_len = 8'd7; i_size = 3'd2; arready = 1; want_rv = 1;
        step();
        chk("i8_arvalid_t", obs_arvalid, 0);
        step();
        chk("i8_arvalid_t1", obs_arvalid, 1);
        chk("i8_arid", obs_arid, 0);
        chk("i8_arlen", obs_arlen, 7);
        chk("i8_arburst", obs_arburst, 1);
        chk("i8_gnt", obs_i_gnt, 1);
        i_req = 0;
        beats = 0; dbeats = 0; last_at = -1;
        for (int k = 0; k < 20 && m_busy; k++) begin
            step();
            if (obs_i_rvalid) beats++;
            if (obs_d_rvalid) dbeats++;
            if (obs_i_rvalid && obs_i_rlast) last_at = beats;
        end
        chk("i8_beats", beats, 8);
        chk("i8_dbeats", dbeats, 0);
        chk("i8_rlast_at", last_at, 8);
        step();
        chk("i8_idle_rready", obs_rready, 0);
        chk("i8_idle_arvalid", obs_arvalid, 0);

        // D request with arready low for 3 cycles
        d_req = 1; d_addr = 32'h8000_1000; d_len = 8'd0; d_size = 3'd2; arready = 0;
        step();
        arv_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            arv_cnt += int'(obs_arvalid);
            chk("dwait_araddr", obs_araddr, 32'h8000_1000);
            chk("dwait_gnt", obs_d_gnt, 0);
        end
        arready = 1;
        step();
        arv_cnt += int'(obs_arvalid);
        chk("dwait_gnt_hs", obs_d_gnt, 1);
        chk("dwait_arvalid_cycles", arv_cnt, 4);
        d_req = 0;
        drain(20);
        chk("model_last_d", m_last, 1);

        // Simultaneous requests twice, starting from reset
        rst = 1; step(); rst = 0;
        i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h200; i_len = 1; d_len = 1; arready = 1;
        step(); step();
        chk("simul1_d_gnt", obs_d_gnt, 1);
        chk("simul1_i_gnt", obs_i_gnt, 0);
        i_req = 0; d_req = 0;
        drain(20);
        i_req = 1; d_req = 1;
        step(); step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("simul2_i_gnt", obs_i_gnt, 1);
        chk("simul2_d_gnt", obs_d_gnt, 0);
`else
        chk("simul2_d_gnt", obs_d_gnt, 1);
        chk("simul2_i_gnt", obs_i_gnt, 0);
`endif
        i_req = 0; d_req = 0;
        drain(20);

        // I request arriving during a D burst
        d_req = 1; d_addr = 32'h4000; d_len = 8'd3; arready = 1; want_rv = 1;
        step(); step();
        d_req = 0;
        step();
        i_req = 1; i_addr = 32'h2000; i_len = 8'd0;
        got = 0;
        for (int k = 0; k < 12 && got == 0; k++) begin
            step();
            if (obs_d_rvalid && obs_d_rlast) got = 1;
            else chk("midburst_arvalid", obs_arvalid, 0);
        end
        chk("midburst_rlast_seen", got, 1);
        step();
        chk("midburst_u1_arvalid", obs_arvalid, 0);
        step();
        chk("midburst_u2_arvalid", obs_arvalid, 1);
        chk("midburst_u2_arid", obs_arid, 0);
        i_req = 0;
        drain(20);

        // Gapped beats 1,0,0,1
        i_req = 1; i_addr = 32'h3000; i_len = 8'd1; arready = 1;
        step(); step();
        i_req = 0;
        pat = '{1, 0, 0, 1};
        beats = 0;
        for (int k = 0; k < 4; k++) begin
            want_rv = (pat[k] != 0);
            step();
            chk("gap_rready", obs_rready, 1);
            if (obs_i_rvalid) beats++;
        end
        chk("gap_beats", beats, 2);
        want_rv = 1;
        step();
        chk("gap_idle_rready", obs_rready, 0);

        // Reset in the middle of a data burst
        i_req = 1; i_addr = 32'h5000; i_len = 8'd3; arready = 1; want_rv = 1;
        step(); step();
        i_req = 0;
        step(); step();
        rst = 1; want_rv = 0;
        step();
        rst = 0;
        step();
        chk("rst_rready", obs_rready, 0);
        chk("rst_arvalid", obs_arvalid, 0);
        chk("rst_i_rvalid", obs_i_rvalid, 0);
        chk("rst_d_rvalid", obs_d_rvalid, 0);
        i_req = 1; i_addr = 32'h6000; i_len = 8'd0;
        step(); step();
        chk("rst_reissue_arvalid", obs_arvalid, 1);
        chk("rst_reissue_gnt", obs_i_gnt, 1);
        i_req = 0;
        drain(20);

        // Randomized traffic
        e_ig = 0; e_dg = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (e_ig) begin
                i_req = $urandom_range(0, 1) != 0;
                i_addr = $urandom; i_len = 8'($urandom_range(0, 5)); i_size = 3'($urandom_range(0, 7));
            end else if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1;
                i_addr = $urandom; i_len = 8'($urandom_range(0, 5)); i_size = 3'($urandom_range(0, 7));
            end
            if (e_dg) begin
                d_req = $urandom_range(0, 1) != 0;
                d_addr = $urandom; d_len = 8'($urandom_range(0, 5)); d_size = 3'($urandom_range(0, 7));
            end else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1;
                d_addr = $urandom; d_len = 8'($urandom_range(0, 5)); d_size = 3'($urandom_range(0, 7));
            end
            arready = $urandom_range(0, 2) != 0;
            want_rv = $urandom_range(0, 3) != 0;
            rst     = $urandom_range(0, 399) == 0;
            step();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the single AXI read address and read data channels between the instruction-side and data-side read requesters inside `mmu_top`. It serialises I-cache refills, D-cache refills and uncached loads onto one outstanding AXI read at a time. It tags each burst with `arid` by owner and steers returned beats back to the owner.

## Interface
Parameters:
- `ADDR_W`, 32: requester and AXI address width.

Ports (clock and reset first):
- `clk`  in  1  system clock (`aclk`)
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  instruction-side read request (level)
- `i_addr`  in  ADDR_W  instruction burst start address
- `i_len`  in  8  AXI beat count minus 1
- `i_size`  in  3  AXI beat size
- `i_gnt`  out  1  one-cycle pulse: AR handshake done for the I request
- `i_rdata`  out  32  returned beat (valid when `i_rvalid`)
- `i_rvalid`  out  1  I beat valid
- `i_rlast`  out  1  last I beat
- `d_req`, `d_addr`, `d_len`, `d_size`, `d_gnt`, `d_rdata`, `d_rvalid`, `d_rlast`: same as the `i_*` ports, data side
- `arid`  out  4  0 = I owner, 1 = D owner
- `araddr`  out  32;  `arlen`  out  8;  `arsize`  out  3
- `arburst`  out  2  constant 2'b01 (INCR)
- `arlock`  out  2  constant 0;  `arcache`  out  4  constant 0;  `arprot`  out  3  constant 0
- `arvalid`  out  1;  `arready`  in  1
- `rid`  in  4;  `rdata`  in  32;  `rresp`  in  2;  `rlast`  in  1;  `rvalid`  in  1;  `rready`  out  1

## Operation
- FSM states:
  - IDLE: no request accepted.
  - ADDR: `arvalid` asserted.
  - DATA: `rready` asserted.
- IDLE: if any request is pending, pick the owner (see Configuration), latch its addr/len/size and owner into registers, and go to ADDR. With no request, stay in IDLE.
- ADDR: `arvalid`=1 driven from the latched registers. On `arvalid & arready`, pulse the owner's `x_gnt` for that same cycle and go to DATA. The AR fields stay stable while waiting.
- DATA: `rready`=1.
  - The owner's `x_rvalid` = `rvalid`, `x_rdata` = `rdata` and `x_rlast` = `rlast`, all combinational. The non-owner's outputs are 0.
  - On `rvalid & rlast`, go to IDLE.
- At most one AXI read is outstanding. `rid` and `rresp` are not checked.
- Requesters hold `req`, `addr`, `len` and `size` stable until their `gnt`, and drop `req` in the cycle after `gnt` unless they want another burst.
- The arbiter ignores `x_req` from gnt+1 until it returns to IDLE, so a req held high re-issues only after the current burst completes.

## Timing
- Reset values: state IDLE, `arvalid`=0, `rready`=0, all `x_gnt`/`x_rvalid`/`x_rlast`=0, `araddr`/`arlen`/`arsize`/`arid`=0, RR pointer = I last served.
- Request seen in IDLE at cycle t gives `arvalid`=1 at t+1. With `arready` held high, `gnt` fires at t+1.
- First beat can be accepted at t+2. A single-beat read completes at the earliest at t+2.
- `rlast` beat at cycle u: IDLE at u+1. The next `arvalid` rises at u+2 at the earliest (one dead cycle between bursts).
- `rvalid` low in DATA: wait, with `rready` held at 1.
- `rst` asserted in any state returns all outputs to their reset values at the next edge. In-flight beats are dropped; the AXI slave shares the same reset.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both `i_req` and `d_req` are pending in IDLE, grant the requester not served last. A 1-bit pointer updates on each AR handshake.
- Not defined: fixed priority. The D side always wins simultaneous requests; the pointer logic is removed.
- Single requests are granted immediately in both builds.

## Test plan
- `i_req`, `i_addr`=0x1FC0_0000, `i_len`=7, `arready`=1 -> `arvalid` for 1 cycle with `arid`=0, `arlen`=7, `arburst`=1. Then 8 `rvalid` beats appear only on `i_*`, `i_rlast` on the 8th, and state is IDLE the next cycle.
- `d_req` with `arready` low for 3 cycles -> `arvalid` held 3+1 cycles with `araddr` stable, and one `d_gnt` pulse in the handshake cycle.
- `i_req` and `d_req` both rising in one cycle, repeated twice, without the macro -> grants D, D. With `ARB_ROUND_ROBIN_EN` -> grants D, I.
- D burst in DATA, `i_req` asserted mid-burst -> no `arvalid` until 2 cycles after D `rlast`, then `arid`=0.
- Gapped `rvalid` (1,0,0,1 with `rlast`) -> `rready` stays 1, exactly 2 beats forwarded.
- `rst` pulsed while in DATA after 2 of 4 beats -> next cycle `rready`=0, `arvalid`=0 and all `x_rvalid`=0; a new `i_req` after reset issues normally.
